// File: rtl/m_countdown_timer_if.sv
// m_countdown_timer_if: control, preset and display signals of the BCD countdown timer.
// master drives control/presets and reads the display; slave is the timer side.
interface m_countdown_timer_if;
    logic       tick;
    logic       start_stop;
    logic       load;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [7:0] preset_msec;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] msec;
    logic       run_led;
    logic       alarm;

    modport master (
        output tick, start_stop, load, preset_min, preset_sec, preset_msec,
        input  min, sec, msec, run_led, alarm
    );

    modport slave (
        input  tick, start_stop, load, preset_min, preset_sec, preset_msec,
        output min, sec, msec, run_led, alarm
    );
endinterface

// File: rtl/m_countdown_timer.sv
// m_countdown_timer: BCD mm:ss.cc countdown timer, alarm on reaching 00:00.00.
// Define CDT_INT_TICK_EN to derive the 1/100 s tick internally (TICK_DIV clocks per tick).
module m_countdown_timer
`ifdef CDT_INT_TICK_EN
#(
    parameter int unsigned TICK_DIV = 32'd500000
)
`endif
(
    input  logic                clk,
    input  logic                reset,
    m_countdown_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] count_q, count_d;
    logic        run_led_q, run_led_d;
    logic        alarm_q, alarm_d;
    logic        tick_s;
    logic        count_zero_s;
    logic        count_one_s;
    logic [23:0] preset_s;
    logic [23:0] count_dec_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
        logic [3:0] r;
        if (d > max_d) begin
            r = max_d;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Count layout {min tens, min ones, sec tens, sec ones, cc tens, cc ones}; borrow ripples upward.
    function automatic logic [23:0] bcd_dec(input logic [23:0] c);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  dig;
        logic [3:0]  wrap;
        r      = c;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dig = c[i*4 +: 4];
            if (i == 3) begin
                wrap = 4'd5;
            end else begin
                wrap = 4'd9;
            end
            if (!borrow) begin
                r[i*4 +: 4] = dig;
            end else if (dig != 4'd0) begin
                r[i*4 +: 4] = dig - 4'd1;
                borrow      = 1'b0;
            end else if (i == 5) begin
                r[i*4 +: 4] = 4'd0;
                borrow      = 1'b0;
            end else begin
                r[i*4 +: 4] = wrap;
            end
        end
        return r;
    endfunction

`ifdef CDT_INT_TICK_EN
    localparam int unsigned      DIV_W    = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 32'd1);

    logic [DIV_W-1:0] div_q, div_d;

    // Free-running divider next value
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_s = (div_q == DIV_LAST);
`else
    assign tick_s = bus.tick;
`endif

    assign preset_s = {clamp_digit(bus.preset_min[7:4],  4'd5), clamp_digit(bus.preset_min[3:0],  4'd9),
                       clamp_digit(bus.preset_sec[7:4],  4'd5), clamp_digit(bus.preset_sec[3:0],  4'd9),
                       clamp_digit(bus.preset_msec[7:4], 4'd9), clamp_digit(bus.preset_msec[3:0], 4'd9)};
    assign count_dec_s  = bcd_dec(count_q);
    assign count_zero_s = (count_q == 24'h00_00_00);
    assign count_one_s  = (count_q == 24'h00_00_01);

    // Next state and count; load has priority over start_stop
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    count_d = preset_s;
                end else if (bus.start_stop && !count_zero_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (tick_s) begin
                    count_d = count_dec_s;
                    if (count_one_s) begin
                        state_d = S_DONE;
                    end else if (bus.start_stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (bus.start_stop) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (bus.load) begin
                    count_d = preset_s;
                    state_d = S_IDLE;
                end else if (bus.start_stop) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_DONE: begin
                if (bus.load) begin
                    count_d = preset_s;
                    state_d = S_IDLE;
                end else if (bus.start_stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 24'h00_00_00;
            end
        endcase
    end

    // Status outputs follow the next state so they move on the same edge as the state
    always_comb begin
        run_led_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_DONE);
    end

    // State, count and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 24'h00_00_00;
            run_led_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            run_led_q <= run_led_d;
            alarm_q   <= alarm_d;
        end
    end

    assign bus.min     = count_q[23:16];
    assign bus.sec     = count_q[15:8];
    assign bus.msec    = count_q[7:0];
    assign bus.run_led = run_led_q;
    assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_m_countdown_timer.sv
// tb_m_countdown_timer: vector table, corner sequences and random stimulus against a
// hundredths-of-a-second arithmetic model of the countdown timer.
`timescale 1ns/1ps
module tb_m_countdown_timer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    m_countdown_timer_if tif();

`ifdef CDT_INT_TICK_EN
    m_countdown_timer #(.TICK_DIV(4)) dut (.clk(clk), .reset(reset), .bus(tif));
`else
    m_countdown_timer dut (.clk(clk), .reset(reset), .bus(tif));
`endif

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_total;
    int m_mode;

    typedef struct {
        logic        ld, ss, tk;
        logic [7:0]  pm, ps, pc;
        logic [25:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[14];

    function automatic logic [25:0] pack(logic [7:0] m, logic [7:0] s, logic [7:0] c, logic r, logic a);
        return {m, s, c, r, a};
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int clamp_val(logic [7:0] v, int tmax);
        int t, o;
        t = (int'(v[7:4]) > tmax) ? tmax : int'(v[7:4]);
        o = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [25:0] model_out();
        return pack(to_bcd(m_total / 6000), to_bcd((m_total / 100) % 60), to_bcd(m_total % 100),
                    m_mode == M_RUN, m_mode == M_DONE);
    endfunction

    function automatic logic [25:0] dut_out();
        return {tif.min, tif.sec, tif.msec, tif.run_led, tif.alarm};
    endfunction

    task automatic model_step(logic ld, logic ss, logic tk, logic [7:0] pm, logic [7:0] ps, logic [7:0] pc);
        if (ld && m_mode != M_RUN) begin
            m_total = clamp_val(pm, 5) * 6000 + clamp_val(ps, 5) * 100 + clamp_val(pc, 9);
            m_mode  = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (ss && m_total != 0) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (tk) m_total = m_total - 1;
            if (m_total == 0) m_mode = M_DONE;
            else if (ss) m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (ss) m_mode = M_RUN;
        end else if (ss) begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic check(string name, logic [25:0] got, logic [25:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h_%h_%h run=%b alarm=%b, required %h_%h_%h run=%b alarm=%b", name,
                     got[25:18], got[17:10], got[9:2], got[1], got[0],
                     exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic cycle(logic ld, logic ss, logic tk, logic [7:0] pm, logic [7:0] ps, logic [7:0] pc);
        tif.load = ld; tif.start_stop = ss; tif.tick = tk;
        tif.preset_min = pm; tif.preset_sec = ps; tif.preset_msec = pc;
        @(posedge clk);
        #1;
        model_step(ld, ss, tk, pm, ps, pc);
        check("model", dut_out(), model_out());
        tif.load = 1'b0; tif.start_stop = 1'b0; tif.tick = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, pack(8'h00, 8'h00, 8'h03, 1'b0, 1'b0), "load_3"};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h03, 1'b1, 1'b0), "start"};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h02, 1'b1, 1'b0), "tick_02"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h01, 1'b1, 1'b0), "tick_01"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b1), "tick_done"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0), "alarm_ack"};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0), "start_zero"};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h9A, 8'h7C, 8'hFF, pack(8'h59, 8'h59, 8'h99, 1'b0, 1'b0), "clamp"};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h59, 8'h59, 8'h99, 1'b1, 1'b0), "start2"};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, pack(8'h59, 8'h59, 8'h99, 1'b1, 1'b0), "load_in_run"};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h59, 8'h59, 8'h99, 1'b0, 1'b0), "pause"};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, pack(8'h12, 8'h34, 8'h56, 1'b0, 1'b0), "load_beats_ss"};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0), "load_zero"};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0), "start_zero2"};

        reset = 1'b1;
        tif.load = 1'b0; tif.start_stop = 1'b0; tif.tick = 1'b0;
        tif.preset_min = 8'h00; tif.preset_sec = 8'h00; tif.preset_msec = 8'h00;
        m_total = 0; m_mode = M_IDLE;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        reset = 1'b0;

`ifdef CDT_INT_TICK_EN
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02);
        tif.start_stop = 1'b1;
        @(posedge clk);
        #1;
        tif.start_stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tif.alarm) break;
            tif.tick = 1'($urandom % 2);
            @(posedge clk);
            #1;
        end
        tif.tick = 1'b0;
        check("int_tick_done", dut_out(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b1));
`else
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].ld, vecs[i].ss, vecs[i].tk, vecs[i].pm, vecs[i].ps, vecs[i].pc);
            check(vecs[i].name, dut_out(), vecs[i].exp);
        end

        cycle(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        check("borrow_chain", dut_out(), pack(8'h09, 8'h59, 8'h99, 1'b1, 1'b0));
        for (int i = 0; i < 6000; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        check("one_minute", dut_out(), pack(8'h08, 8'h59, 8'h99, 1'b1, 1'b0));

        cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h01, 8'h23, 8'h45);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        check("tick_ss_run", dut_out(), pack(8'h01, 8'h23, 8'h44, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        check("pause_frozen", dut_out(), pack(8'h01, 8'h23, 8'h44, 1'b0, 1'b0));
        cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        check("tick_ss_pause", dut_out(), pack(8'h01, 8'h23, 8'h44, 1'b1, 1'b0));
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

        // Asynchronous reset between edges while running
        tif.tick = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", dut_out(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        m_total = 0; m_mode = M_IDLE;
        @(posedge clk);
        #1;
        check("reset_held", dut_out(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        reset = 1'b0;
        tif.tick = 1'b0;

        for (int i = 0; i < 800; i++) begin
            logic [7:0] pm, ps, pc;
            if ($urandom % 2 == 0) begin
                pm = 8'h00; ps = 8'h00; pc = 8'($urandom_range(0, 20));
            end else begin
                pm = 8'($urandom); ps = 8'($urandom); pc = 8'($urandom);
            end
            cycle(1'($urandom % 16 == 0), 1'($urandom % 6 == 0), 1'($urandom % 2), pm, ps, pc);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
